// File: rtl/alu_issue_stage.sv
// alu_issue_stage: register-file operand fetch, ALU handoff and writeback.
// Build option FORWARD_EN: bypass alu_result on RAW hazards instead of stalling.
module alu_issue_stage #(
  parameter int ALU_WIDTH = 16,
  parameter int NUM_REGS  = 16,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           in_opcode,
  input  logic [ADDR_W-1:0]    in_rs1_addr,
  input  logic [ADDR_W-1:0]    in_rs2_addr,
  input  logic [ADDR_W-1:0]    in_rd_addr,
  output logic [ALU_WIDTH-1:0] alu_rs1,
  output logic [ALU_WIDTH-1:0] alu_rs2,
  output logic [3:0]           alu_opcode,
  input  logic [ALU_WIDTH-1:0] alu_result,
  output logic                 wb_valid,
  output logic [ADDR_W-1:0]    wb_addr,
  output logic [ALU_WIDTH-1:0] wb_data,
  output logic                 wb_illegal,
  input  logic [ADDR_W-1:0]    dbg_addr,
  output logic [ALU_WIDTH-1:0] dbg_data
);

  function automatic logic legal(input logic [3:0] op);
    case (op)
      4'h0, 4'h8, 4'h1, 4'h2, 4'h3,
      4'h4, 4'h5, 4'hD, 4'h6, 4'h7: legal = 1'b1;
      default:                      legal = 1'b0;
    endcase
  endfunction

  logic [ALU_WIDTH-1:0] rf_q [NUM_REGS];

  logic                 ex_valid_q;
  logic [ADDR_W-1:0]    ex_rd_q;
  logic [ALU_WIDTH-1:0] rs1_q, rs2_q;
  logic [ALU_WIDTH-1:0] rs1_d, rs2_d;
  logic [3:0]           op_q;

  logic                 wb_valid_q;
  logic                 wb_ill_q;
  logic [ADDR_W-1:0]    wb_addr_q;
  logic [ALU_WIDTH-1:0] wb_data_q;

  logic                 ex_wr;
  logic                 hz1, hz2;
  logic                 ready;
  logic                 accept;
  logic [ALU_WIDTH-1:0] rf_rs1, rf_rs2;

  assign ex_wr = ex_valid_q && (ex_rd_q != '0) && legal(op_q);
  assign hz1   = ex_wr && (in_rs1_addr == ex_rd_q);
  assign hz2   = ex_wr && (in_rs2_addr == ex_rd_q);

  assign rf_rs1 = (in_rs1_addr == '0) ? '0 : rf_q[in_rs1_addr];
  assign rf_rs2 = (in_rs2_addr == '0) ? '0 : rf_q[in_rs2_addr];

  always_comb begin
    rs1_d = rf_rs1;
    rs2_d = rf_rs2;
    ready = 1'b1;
`ifdef FORWARD_EN
    if (hz1) rs1_d = alu_result;
    if (hz2) rs2_d = alu_result;
`else
    ready = !(hz1 || hz2);
`endif
  end

  assign accept = in_valid && ready;

  // the write lands on the same edge that issues the next instruction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
    end else if (ex_wr) begin
      rf_q[ex_rd_q] <= alu_result;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      ex_rd_q    <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      op_q       <= '0;
    end else begin
      ex_valid_q <= accept;
      if (accept) begin
        ex_rd_q <= in_rd_addr;
        rs1_q   <= rs1_d;
        rs2_q   <= rs2_d;
        op_q    <= in_opcode;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      wb_ill_q   <= 1'b0;
    end else begin
      wb_valid_q <= ex_valid_q;
      if (ex_valid_q) begin
        wb_addr_q <= ex_rd_q;
        wb_data_q <= alu_result;
        wb_ill_q  <= !legal(op_q);
      end
    end
  end

  assign in_ready   = ready;
  assign alu_rs1    = rs1_q;
  assign alu_rs2    = rs2_q;
  assign alu_opcode = op_q;
  assign wb_valid   = wb_valid_q;
  assign wb_addr    = wb_addr_q;
  assign wb_data    = wb_data_q;
  assign wb_illegal = wb_ill_q;
  assign dbg_data   = (dbg_addr == '0) ? '0 : rf_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed program with an architectural reference
// model, a bench-side ALU and per-cycle output comparison.
module tb_alu_issue_stage;

`ifdef FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h8;
  localparam logic [3:0] OP_SLL  = 4'h1;
  localparam logic [3:0] OP_SLT  = 4'h2;
  localparam logic [3:0] OP_SLTU = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_SRL  = 4'h5;
  localparam logic [3:0] OP_SRA  = 4'hD;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_AND  = 4'h7;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_opcode;
  logic [3:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic [15:0] alu_rs1, alu_rs2;
  logic [3:0]  alu_opcode;
  logic [15:0] alu_result;
  logic        wb_valid;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic        wb_illegal;
  logic [3:0]  dbg_addr;
  logic [15:0] dbg_data;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_rs1_addr(in_rs1_addr),
    .in_rs2_addr(in_rs2_addr),
    .in_rd_addr (in_rd_addr),
    .alu_rs1    (alu_rs1),
    .alu_rs2    (alu_rs2),
    .alu_opcode (alu_opcode),
    .alu_result (alu_result),
    .wb_valid   (wb_valid),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .wb_illegal (wb_illegal),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
               $time);
    end
  endtask

  function automatic logic [15:0] alu_fn(input logic [3:0] op,
                                         input logic [15:0] a,
                                         input logic [15:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_SLL:  return a << b[3:0];
      OP_SLT:  return {15'd0, $signed(a) < $signed(b)};
      OP_SLTU: return {15'd0, a < b};
      OP_XOR:  return a ^ b;
      OP_SRL:  return a >> b[3:0];
      OP_SRA:  return 16'($signed(a) >>> b[3:0]);
      OP_OR:   return a | b;
      OP_AND:  return a & b;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic bit legal_op(input logic [3:0] op);
    return op inside {OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU,
                      OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND};
  endfunction

  // Bench ALU; injection lets the program seed non-zero constants.
  logic        drv_inj;
  logic [15:0] drv_injv;
  logic        ex_inj;
  logic [15:0] inj_q;

  always_comb begin
    alu_result = ex_inj ? inj_q : alu_fn(alu_opcode, alu_rs1, alu_rs2);
  end

  typedef struct {
    int          acc;
    logic [3:0]  rd;
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    bit          ill;
  } ent_t;

  ent_t        q[$];
  ent_t        pend_e;
  bit          pend = 1'b0;
  bit          pend_inj = 1'b0;
  logic [15:0] pend_injv = '0;
  logic [15:0] arch [16];
  logic [15:0] comm [16];
  int          cyc = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_inj <= 1'b0;
      inj_q  <= '0;
    end else begin
      ex_inj <= pend && pend_inj;
      inj_q  <= pend_injv;
    end
  end

  // Reference model: program-order state plus committed register view.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      for (int i = 0; i < 16; i++) begin
        arch[i] = '0;
        comm[i] = '0;
      end
      cyc = 0;
    end else begin
      cyc++;
      foreach (q[i])
        if (q[i].acc + 1 == cyc && !q[i].ill && q[i].rd != 0)
          comm[q[i].rd] = q[i].res;
      q = q.find(e) with (e.acc + 1 >= cyc);
      if (pend) begin
        pend_e.acc = cyc;
        q.push_back(pend_e);
      end
    end
  end

  always @(negedge clk) begin
    bit wb_seen;
    bit hz;
    if (rst) begin
      pend = 1'b0;
    end else begin
      wb_seen = 1'b0;
      hz      = 1'b0;
      foreach (q[i]) begin
        if (q[i].acc == cyc) begin
          chk("alu_rs1", alu_rs1, q[i].a);
          chk("alu_rs2", alu_rs2, q[i].b);
          chk("alu_opcode", alu_opcode, q[i].op);
          if (!q[i].ill && q[i].rd != 0 &&
              (in_rs1_addr == q[i].rd || in_rs2_addr == q[i].rd))
            hz = 1'b1;
        end
        if (q[i].acc + 1 == cyc) begin
          wb_seen = 1'b1;
          chk("wb_valid", wb_valid, 1);
          chk("wb_addr", wb_addr, q[i].rd);
          chk("wb_data", wb_data, q[i].res);
          chk("wb_illegal", wb_illegal, q[i].ill);
        end
      end
      if (!wb_seen) chk("wb_valid idle", wb_valid, 0);
      chk("dbg_data", dbg_data, comm[dbg_addr]);
      if (in_valid) chk("in_ready", in_ready, (hz && !FWD) ? 0 : 1);
      pend = in_valid && in_ready;
      pend_inj  = drv_inj;
      pend_injv = drv_injv;
      if (pend) begin
        pend_e.rd  = in_rd_addr;
        pend_e.op  = in_opcode;
        pend_e.a   = arch[in_rs1_addr];
        pend_e.b   = arch[in_rs2_addr];
        pend_e.ill = !legal_op(in_opcode);
        pend_e.res = drv_inj ? drv_injv
                             : alu_fn(in_opcode, pend_e.a, pend_e.b);
        if (!pend_e.ill && in_rd_addr != 0)
          arch[in_rd_addr] = pend_e.res;
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  // Call at posedge+2; returns at posedge+2 after the accepting edge.
  task automatic issue(input logic [3:0] op, input logic [3:0] rd,
                       input logic [3:0] rs1, input logic [3:0] rs2,
                       input bit inj, input logic [15:0] injv,
                       output int st);
    in_valid    = 1'b1;
    in_opcode   = op;
    in_rd_addr  = rd;
    in_rs1_addr = rs1;
    in_rs2_addr = rs2;
    drv_inj     = inj;
    drv_injv    = injv;
    st = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      st++;
      if (st > 8) begin
        checks++;
        fails++;
        $display("FAIL accept timeout: op %0h rd %0d not accepted", op, rd);
        break;
      end
    end
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    drv_inj  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int st;
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_opcode   = '0;
    in_rs1_addr = '0;
    in_rs2_addr = '0;
    in_rd_addr  = '0;
    dbg_addr    = '0;
    drv_inj     = 1'b0;
    drv_injv    = '0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    chk("reset in_ready", in_ready, 1);
    chk("reset wb_valid", wb_valid, 0);
    chk("reset alu_rs1", alu_rs1, 0);
    chk("reset alu_opcode", alu_opcode, 0);
    for (int a = 0; a < 16; a++) begin
      dbg_addr = 4'(a);
      settle();
      chk("reset dbg sweep", dbg_data, 0);
    end
    sync();

    issue(OP_ADD, 4'd1, 4'd0, 4'd0, 1'b0, 16'h0, st);
    issue(OP_SUB, 4'd2, 4'd0, 4'd1, 1'b0, 16'h0, st);
    repeat (2) settle();
    dbg_addr = 4'd1;
    settle();
    chk("r1 after add r0+r0", dbg_data, 0);
    dbg_addr = 4'd2;
    settle();
    chk("r2 after sub", dbg_data, 0);
    sync();

    issue(OP_ADD, 4'd1, 4'd0, 4'd0, 1'b1, 16'd1, st);
    issue(OP_ADD, 4'd2, 4'd1, 4'd1, 1'b0, 16'h0, st);
    issue(OP_ADD, 4'd3, 4'd2, 4'd2, 1'b0, 16'h0, st);
    issue(OP_ADD, 4'd2, 4'd2, 4'd1, 1'b0, 16'h0, st);
    issue(OP_ADD, 4'd1, 4'd3, 4'd1, 1'b0, 16'h0, st);
    issue(OP_ADD, 4'd6, 4'd3, 4'd2, 1'b0, 16'h0, st);
    repeat (3) settle();
    dbg_addr = 4'd1;
    settle();
    chk("r1 built", dbg_data, 16'd5);
    dbg_addr = 4'd2;
    settle();
    chk("r2 built", dbg_data, 16'd3);
    sync();

    issue(OP_SUB, 4'd3, 4'd1, 4'd2, 1'b0, 16'h0, st);
    settle();
    chk("sub wb early", wb_valid, 0);
    settle();
    chk("sub wb_valid", wb_valid, 1);
    chk("sub wb_addr", wb_addr, 3);
    chk("sub wb_data", wb_data, 16'd2);
    sync();

    issue(OP_ADD, 4'd4, 4'd1, 4'd2, 1'b0, 16'h0, st);
    issue(OP_XOR, 4'd5, 4'd4, 4'd1, 1'b0, 16'h0, st);
    chk("raw stall cycles", st, FWD ? 0 : 1);
    repeat (3) settle();
    dbg_addr = 4'd5;
    settle();
    chk("r5 xor result", dbg_data, 16'h000D);
    sync();

    issue(OP_ADD, 4'd0, 4'd1, 4'd2, 1'b0, 16'h0, st);
    settle();
    settle();
    chk("r0 wb_valid", wb_valid, 1);
    chk("r0 wb_data", wb_data, 16'd8);
    chk("r0 wb_addr", wb_addr, 0);
    dbg_addr = 4'd0;
    settle();
    chk("r0 stays zero", dbg_data, 0);
    sync();

    issue(4'hF, 4'd6, 4'd1, 4'd2, 1'b0, 16'h0, st);
    settle();
    settle();
    chk("illegal wb_valid", wb_valid, 1);
    chk("illegal wb_illegal", wb_illegal, 1);
    dbg_addr = 4'd6;
    settle();
    chk("r6 untouched", dbg_data, 16'h0007);
    sync();

    issue(OP_SLL,  4'd8,  4'd1,  4'd2, 1'b0, 16'h0, st);
    issue(OP_SUB,  4'd10, 4'd0,  4'd1, 1'b0, 16'h0, st);
    issue(OP_SRA,  4'd11, 4'd10, 4'd2, 1'b0, 16'h0, st);
    issue(OP_SRL,  4'd12, 4'd10, 4'd2, 1'b0, 16'h0, st);
    issue(OP_SLT,  4'd13, 4'd10, 4'd1, 1'b0, 16'h0, st);
    issue(OP_SLTU, 4'd14, 4'd10, 4'd1, 1'b0, 16'h0, st);
    issue(OP_OR,   4'd15, 4'd1,  4'd8, 1'b0, 16'h0, st);
    issue(OP_AND,  4'd9,  4'd15, 4'd2, 1'b0, 16'h0, st);
    issue(OP_SRA,  4'd7,  4'd1,  4'd2, 1'b0, 16'h0, st);
    chk("wb before reset", wb_valid, 1);
    rst = 1'b1;
    #1;
    chk("async wb clear", wb_valid, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    chk("post reset in_ready", in_ready, 1);
    chk("post reset wb_valid", wb_valid, 0);
    for (int a = 0; a < 16; a++) begin
      dbg_addr = 4'(a);
      settle();
      chk("post reset dbg sweep", dbg_data, 0);
    end
    chk("post reset wb idle", wb_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Operand-fetch and writeback stage wrapped around the execute ALU. It accepts decoded instructions over a valid/ready handshake and reads two source registers from an internal register file. It presents the registered operands and opcode to the ALU, then captures the ALU result one cycle later and writes it back to the destination register. RAW hazards between back-to-back instructions are resolved by forwarding or stalling, selected at compile time.

## Interface
- ALU_WIDTH, 16, data width of registers and ALU operands.
- NUM_REGS, 16, register count, power of two; ADDR_W = $clog2(NUM_REGS).
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  instruction offered.
- in_ready  out  1  stage can accept; transfer when in_valid && in_ready.
- in_opcode  in  4  ALU opcode.
- in_rs1_addr, in_rs2_addr  in  ADDR_W  source register indices.
- in_rd_addr  in  ADDR_W  destination register index.
- alu_rs1, alu_rs2  out  ALU_WIDTH  operands to the ALU (registered).
- alu_opcode  out  4  opcode to the ALU (registered).
- alu_result  in  ALU_WIDTH  combinational result back from the ALU.
- wb_valid  out  1  one-cycle pulse per retired instruction.
- wb_addr  out  ADDR_W  destination of the retired instruction.
- wb_data  out  ALU_WIDTH  result written.
- wb_illegal  out  1  retired instruction had an illegal opcode.
- dbg_addr  in  ADDR_W  debug read index.
- dbg_data  out  ALU_WIDTH  combinational read of regfile[dbg_addr]; reads of index 0 return 0.

## Operation
- Register file: NUM_REGS × ALU_WIDTH. Register 0 is hardwired to zero, and writes to it are dropped. One write port and three combinational read ports (rs1, rs2, dbg).
- Legal opcodes: 0000 ADD, 1000 SUB, 0001 SLL, 0010 SLT, 0011 SLTU, 0100 XOR, 0101 SRL, 1101 SRA, 0110 OR, 0111 AND. Every other opcode is illegal.
- Issue stage (on an accepted transfer):
  - Latch the operands into alu_rs1/alu_rs2.
  - Latch in_opcode into alu_opcode and in_rd_addr into ex_rd.
  - Set ex_valid.
  - With no accepted transfer, ex_valid clears and alu_* hold their values.
- Execute/writeback (on each edge where ex_valid=1):
  - If the opcode is legal and ex_rd≠0, write regfile[ex_rd] <= alu_result.
  - Register wb_valid=1, wb_addr=ex_rd and wb_data=alu_result.
  - Register wb_illegal = !legal(alu_opcode).
  - Illegal opcodes never write the register file.
- Hazard condition: ex_valid && ex_rd≠0 && legal(alu_opcode) && (in_rs1_addr==ex_rd || in_rs2_addr==ex_rd), with per-port matching.
- The register file is written on the same edge that issues the next instruction. An instruction two or more slots behind its producer therefore reads the updated value with no bypass.
- No internal queue: the stage holds at most one instruction in EX plus one retire record.

## Timing
- Reset values:
  - in_ready=1.
  - alu_rs1, alu_rs2 and alu_opcode = 0.
  - ex_valid=0.
  - wb_valid, wb_addr, wb_data and wb_illegal = 0.
  - All registers = 0.
- Latency, for an instruction accepted at edge N:
  - Operands are on alu_* during cycle N+1.
  - The register file is written at edge N+1 (end of cycle N+1).
  - wb_valid is high during cycle N+2.
- Throughput: one instruction per cycle when there is no stall.
- in_ready is combinational from in_* and EX state. in_valid may depend on in_ready only through registered logic.
- Reset asserted mid-operation: the in-flight EX instruction is discarded with no register write. wb_valid clears immediately (asynchronously).

## Configuration
- FORWARD_EN defined:
  - On the hazard condition, the matching operand is taken from alu_result instead of the register file.
  - in_ready stays 1 at all times outside reset.
- FORWARD_EN undefined:
  - On the hazard condition, in_ready=0 for that cycle and nothing is accepted.
  - The instruction issues on the following cycle from the updated register file.
  - Dependent back-to-back pairs therefore cost one bubble.

## Test plan
- Reset, then dbg sweep over all addresses -> every dbg_data=0; in_ready=1; wb_valid=0.
- Preload: ADD r1=r0+r0 with no prior data -> r1 stays 0. Then SUB r2=r0-r1 -> r2=0. Then a sequence building r1=5 and r2=3 via ADD chains, followed by SUB r3=r1-r2 -> wb_data=2, wb_addr=3, exactly two cycles after acceptance.
- Back-to-back dependency ADD r4=r1+r2 then XOR r5=r4^r1 (r1=5, r2=3):
  - FORWARD_EN: no stall, r5=0x000D.
  - Without FORWARD_EN: in_ready low for exactly one cycle, r5=0x000D.
- Write to r0 (ADD r0=r1+r2) -> wb_valid=1, wb_data=8; dbg read of r0 remains 0.
- Illegal opcode 1111 targeting r6 (r6 holding 0x0007) -> wb_valid=1, wb_illegal=1; r6 still 0x0007.
- Assert rst for one cycle while SRA r7 is in EX -> r7 unchanged (0); wb_valid=0; all registers 0; in_ready=1 after release.
